// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access-type codes, access size and splitter state.
package lsu_pkg;

    localparam logic [2:0] SLT_SB  = 3'b000;
    localparam logic [2:0] SLT_SH  = 3'b001;
    localparam logic [2:0] SLT_SW  = 3'b010;
    localparam logic [2:0] SLT_LB  = 3'b011;
    localparam logic [2:0] SLT_LH  = 3'b100;
    localparam logic [2:0] SLT_LW  = 3'b101;
    localparam logic [2:0] SLT_LBU = 3'b110;
    localparam logic [2:0] SLT_LHU = 3'b111;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

    typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_e;

endpackage

// File: rtl/lsu_misalign_ctrl_if.sv
// Memory-stage request bus into the misalignment splitter and its lsu_ms2-side outputs.
interface lsu_misalign_ctrl_if #(parameter int CNT_W = 16);

    // Handshake: i_req is valid; o_stall acts as an inverted ready. A request is
    // consumed at the end of a cycle with i_req=1 and o_stall=0, and its inputs
    // must stay stable for every cycle in which o_stall=1.
    logic             i_req;
    logic             i_wren;
    logic [31:0]      i_addr;
    logic [31:0]      i_st_data;
    logic [2:0]       i_slt_sl;
    logic [31:0]      i_lsu_ld_data;
    logic             o_stall;
    logic [31:0]      o_lsu_addr;
    logic             o_lsu_wren;
    logic [31:0]      o_lsu_st_data;
    logic [2:0]       o_lsu_slt_sl;
    logic [31:0]      o_ld_data;
    logic             o_ld_valid;
    logic [CNT_W-1:0] o_misalign_cnt;
    logic [0:0]       o_dbg_state;

    modport slave (
        input  i_req, i_wren, i_addr, i_st_data, i_slt_sl, i_lsu_ld_data,
        output o_stall, o_lsu_addr, o_lsu_wren, o_lsu_st_data, o_lsu_slt_sl,
               o_ld_data, o_ld_valid, o_misalign_cnt, o_dbg_state
    );

    modport master (
        output i_req, i_wren, i_addr, i_st_data, i_slt_sl, i_lsu_ld_data,
        input  o_stall, o_lsu_addr, o_lsu_wren, o_lsu_st_data, o_lsu_slt_sl,
               o_ld_data, o_ld_valid, o_misalign_cnt, o_dbg_state
    );

endinterface

// File: rtl/lsu_size_decode.sv
// Decodes an access type and low address bits into size, byte count, signedness and misalignment.
module lsu_size_decode
    import lsu_pkg::*;
(
    input  logic [2:0] slt_sl,
    input  logic [1:0] addr_lo,
    output size_e      size,
    output logic       misalign,
    output logic [2:0] nbytes,
    output logic       is_signed
);

    always_comb begin
        size   = SZ_B;
        nbytes = 3'd1;
        case (slt_sl)
            SLT_SH, SLT_LH, SLT_LHU: begin
                size   = SZ_H;
                nbytes = 3'd2;
            end
            SLT_SW, SLT_LW: begin
                size   = SZ_W;
                nbytes = 3'd4;
            end
            default: ;
        endcase
        is_signed = (slt_sl == SLT_LB) || (slt_sl == SLT_LH) || (slt_sl == SLT_LW);
        misalign  = ((size == SZ_H) && addr_lo[0]) ||
                    ((size == SZ_W) && (addr_lo != 2'b00));
    end

endmodule

// File: rtl/lsu_misalign_ctrl.sv
// Splits misaligned halfword/word accesses into byte accesses, stalling the pipeline
// and reassembling load data; aligned accesses pass straight through.
module lsu_misalign_ctrl
    import lsu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    lsu_misalign_ctrl_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_SPLIT = SPLIT;

    size_e      live_size;
    logic       live_mis;
    logic [2:0] live_n;
    logic       live_signed;

    lsu_size_decode u_dec (
        .slt_sl    (bus.i_slt_sl),
        .addr_lo   (bus.i_addr[1:0]),
        .size      (live_size),
        .misalign  (live_mis),
        .nbytes    (live_n),
        .is_signed (live_signed)
    );

    logic [0:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      buf_q, buf_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             wren_q, wren_d;
    logic             signed_q, signed_d;
    logic [2:0]       n_q, n_d;
    size_e            size_q, size_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        in_split, start, active, last;
    logic [1:0]  k;
    logic [31:0] base, sdata;
    logic        swren, ssigned;
    logic [2:0]  sn;
    size_e       ssize;
    logic [7:0]  cur_byte, st_byte;
    logic [15:0] half;
    logic [31:0] assembled;
    logic        stall, lsu_wren, ld_valid;
    logic [31:0] lsu_addr, lsu_st_data, ld_data;
    logic [2:0]  lsu_slt;

    always_comb begin
        in_split = (state_q == ST_SPLIT);
        start    = ~in_split & bus.i_req & live_mis;
        active   = in_split | start;
        // Byte 0 comes from the live request; later bytes come from the latched copy.
        k        = in_split ? idx_q    : 2'd0;
        base     = in_split ? addr_q   : bus.i_addr;
        sdata    = in_split ? data_q   : bus.i_st_data;
        swren    = in_split ? wren_q   : bus.i_wren;
        ssigned  = in_split ? signed_q : live_signed;
        sn       = in_split ? n_q      : live_n;
        ssize    = in_split ? size_q   : live_size;
        last     = ({1'b0, k} == (sn - 3'd1));
        cur_byte = bus.i_lsu_ld_data[7:0];
        st_byte  = sdata[{k, 3'b000} +: 8];
        half     = {cur_byte, buf_q[7:0]};
        if (ssize == SZ_W) begin
            assembled = {cur_byte, buf_q};
        end else if (ssigned) begin
            assembled = {{16{half[15]}}, half};
        end else begin
            assembled = {16'h0000, half};
        end

        state_d  = state_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = wren_q;
        signed_d = signed_q;
        n_d      = n_q;
        size_d   = size_q;
        cnt_d    = cnt_q;

        if (start) begin
            state_d  = ST_SPLIT;
            idx_d    = 2'd1;
            addr_d   = bus.i_addr;
            data_d   = bus.i_st_data;
            wren_d   = bus.i_wren;
            signed_d = live_signed;
            n_d      = live_n;
            size_d   = live_size;
        end else if (in_split) begin
            if (last) begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        if (active && !swren && !last) begin
            buf_d[{k, 3'b000} +: 8] = cur_byte;
        end
        if (active && last && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (active) begin
            lsu_addr    = base + {30'd0, k};
            lsu_wren    = swren;
            lsu_st_data = {24'h000000, st_byte};
            lsu_slt     = swren ? SLT_SB : SLT_LBU;
            stall       = ~last;
            ld_valid    = ~swren & last;
            ld_data     = assembled;
        end else begin
            lsu_addr    = bus.i_addr;
            lsu_wren    = bus.i_req & bus.i_wren;
            lsu_st_data = bus.i_st_data;
            lsu_slt     = bus.i_slt_sl;
            stall       = 1'b0;
            ld_valid    = bus.i_req & ~bus.i_wren;
            ld_data     = bus.i_lsu_ld_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            buf_q    <= 24'h000000;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            wren_q   <= 1'b0;
            signed_q <= 1'b0;
            n_q      <= 3'd1;
            size_q   <= SZ_B;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            signed_q <= signed_d;
            n_q      <= n_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
        end
    end

    // Reset gates the side-effecting outputs immediately, so an aborted split issues no more writes.
    assign bus.o_stall        = stall & i_reset_n;
    assign bus.o_lsu_wren     = lsu_wren & i_reset_n;
    assign bus.o_ld_valid     = ld_valid & i_reset_n;
    assign bus.o_ld_data      = i_reset_n ? ld_data : 32'h0;
    assign bus.o_lsu_addr     = lsu_addr;
    assign bus.o_lsu_st_data  = lsu_st_data;
    assign bus.o_lsu_slt_sl   = lsu_slt;
    assign bus.o_misalign_cnt = cnt_q;
    assign bus.o_dbg_state    = state_q;

endmodule

// File: doc/lsu_misalign_ctrl.md
# lsu_misalign_ctrl

Sits between the EX/MEM pipeline register and `lsu_ms2`, upstream of the load/store unit. Aligned accesses pass straight through in one cycle. Misaligned accesses are split into a sequence of single-byte accesses: halfword at byte offset 1 or 3, or word at offset 1, 2 or 3. While the sequence runs, the block stalls the pipeline. For loads it assembles the result and applies sign or zero extension.

## Interface
- `CNT_W`, default 16: width of the saturating misaligned-access counter.
- `i_clk  in  1`: clock, rising edge.
- `i_reset_n  in  1`: reset, asynchronous, active-low.
- `i_req  in  1`: memory-stage access valid.
- `i_wren  in  1`: 1 = store, 0 = load.
- `i_addr  in  32`: byte address.
- `i_st_data  in  32`: store data, right-aligned.
- `i_slt_sl  in  3`: access type; SB=000, SH=001, SW=010, LB=011, LH=100, LW=101, LBU=110, LHU=111.
- `o_stall  out  1`: freeze the upstream pipeline; the request inputs must stay stable while this is high.
- `o_lsu_addr  out  32`, `o_lsu_wren  out  1`, `o_lsu_st_data  out  32`, `o_lsu_slt_sl  out  3`: drive `lsu_ms2`.
- `i_lsu_ld_data  in  32`: `lsu_ms2` `o_ld_data`, combinational read.
- `o_ld_data  out  32`: final load result, valid when `o_ld_valid` is 1.
- `o_ld_valid  out  1`: load result valid this cycle.
- `o_misalign_cnt  out  CNT_W`: number of split accesses completed; saturates at all-ones.

## Operation
- Size: B for codes 000, 011, 110; H for 001, 100, 111; W for 010, 101.
- Misaligned when:
  - H and `addr[0]` = 1, or
  - W and `addr[1:0]` != 0.
- Byte count N: 2 for H, 4 for W.
- States:
  - IDLE: `i_req` && misaligned -> SPLIT; otherwise stay.
  - SPLIT: after issuing the last byte -> IDLE.
- Aligned request, or `i_req` = 0:
  - LSU outputs equal the inputs combinationally.
  - `o_lsu_wren` = `i_req & i_wren`.
  - `o_ld_data` = `i_lsu_ld_data`.
  - `o_ld_valid` = `i_req & ~i_wren`.
  - `o_stall` = 0.
- Misaligned request, byte k = 0..N-1:
  - `o_lsu_addr` = `addr + k`, modulo 2^32; wrap from `FFFF_FFFF` to `0000_0000` is allowed.
  - Store: `o_lsu_slt_sl` = SB, `o_lsu_st_data` = `{24'h0, st_data[8k+7:8k]}`, `o_lsu_wren` = 1.
  - Load: `o_lsu_slt_sl` = LBU, `o_lsu_wren` = 0; `i_lsu_ld_data[7:0]` is captured into `buf[8k+7:8k]`.
  - Byte 0 is issued from the live inputs in the IDLE cycle. The request (addr, data, type, N) is latched at that edge, and bytes 1..N-1 are issued from the latch.
- Load result on the last byte cycle: assembled = `{current byte, buf}`.
  - LH: sign-extend from bit 15.
  - LHU: zero-extend.
  - LW: no extension.
- Word-boundary and region crossing (for example `0x7FF` -> `0x800`) are not special-cased. Each byte follows `lsu_ms2` address decode.
- `o_misalign_cnt` increments by 1 on each last-byte cycle and saturates.

## Timing
- Aligned access: zero added latency, same cycle as the request.
- Misaligned access: N cycles in total.
  - `o_stall` = 1 for cycles 0..N-2 and 0 in cycle N-1.
  - The pipeline advances at the end of cycle N-1.
  - `o_ld_valid` pulses only in cycle N-1.
- A new request can be accepted in the cycle after the last byte; there is no bubble.
- Reset values (while `i_reset_n` = 0):
  - state = IDLE, buf = 0, byte index = 0, `o_misalign_cnt` = 0.
  - `o_stall`, `o_lsu_wren`, `o_ld_valid` forced to 0.
  - `o_ld_data` = 0.
- Reset mid-SPLIT: abort immediately. Bytes already written stay written; no further writes are issued.
- `i_req` dropping during SPLIT is a protocol violation. The block completes from the latched request regardless.

## Structure
- `lsu_pkg` (shared with `lsu_ms2`) holds:
  - the eight `slt_sl` localparams;
  - the size enum {B, H, W};
  - the state enum {IDLE, SPLIT}.
- One combinational sub-module, `lsu_size_decode`: inputs `slt_sl` and `addr[1:0]`; outputs size, misaligned flag, N, and is-signed.
- Everything else (FSM, latch, assembly, counter) stays in `lsu_misalign_ctrl`.

## Test plan
- Aligned LW at `0x0000_0010` with LSU returning `0xDEADBEEF`:
  - `o_ld_data` = `0xDEADBEEF` the same cycle; `o_stall` never high; counter unchanged.
- Misaligned SW of `0x11223344` at `0x0000_0001`:
  - Cycle 0: SB `0x44` to `0x001`.
  - Cycles 1–3: `0x33` to `0x002`, `0x22` to `0x003`, `0x11` to `0x004`.
  - Stall high for 3 cycles; counter = 1.
- Misaligned LH at `0x0000_0003`, LSU returning byte `0x80` then `0xFF`:
  - `o_ld_data` = `0xFFFF_FF80` in cycle 1.
  - Stall high for 1 cycle; `o_ld_valid` high only in cycle 1.
  - Repeat as LHU: `o_ld_data` = `0x0000_FF80`.
- Back-to-back: misaligned LW at `0x0000_0002`, then aligned SB next.
  - SB issues in the cycle right after the last byte, with no bubble.
- Wrap case: SH at `0xFFFF_FFFF`.
  - Byte addresses `0xFFFF_FFFF` then `0x0000_0000`.
- Reset asserted during cycle 1 of a misaligned SW:
  - `o_lsu_wren` drops asynchronously; state = IDLE; no further byte writes.
  - Preload `CNT_W` = 2 at value 3: the counter stays 3 after the next split.
